// File: rtl/cpu_mc_pkg.sv
// Shared types and field positions for the multicycle 16-bit core.
package cpu_mc_pkg;

    typedef enum logic [4:0] {
        OP_MV    = 5'h00,
        OP_ADD   = 5'h01,
        OP_SUB   = 5'h02,
        OP_CMP   = 5'h03,
        OP_LD    = 5'h04,
        OP_ST    = 5'h05,
        OP_JR    = 5'h08,
        OP_JZR   = 5'h09,
        OP_JNR   = 5'h0A,
        OP_CALLR = 5'h0C,
        OP_MVI   = 5'h10,
        OP_ADDI  = 5'h11,
        OP_SUBI  = 5'h12,
        OP_CMPI  = 5'h13,
        OP_MVHI  = 5'h16,
        OP_J     = 5'h18,
        OP_JZ    = 5'h19,
        OP_JN    = 5'h1A,
        OP_CALL  = 5'h1C
    } opcode_e;

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    localparam int OP_LSB    = 0;
    localparam int RX_LSB    = 5;
    localparam int RY_LSB    = 8;
    localparam int IMM8_LSB  = 8;
    localparam int IMM11_LSB = 5;

    // wide=1 extends an 11-bit field, wide=0 extends the low 8 bits
    function automatic logic [15:0] sext(input logic [10:0] v, input logic wide);
        return wide ? {{5{v[10]}}, v} : {{8{v[7]}}, v[7:0]};
    endfunction

endpackage

// File: rtl/cpu_mc_ctrl.sv
// Sequencer for cpu_mc: state machine, opcode legality, bus wait timeout.
module cpu_mc_ctrl
    import cpu_mc_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int WAIT_MAX     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] op,
    input  logic       waitreq,
    output state_e     state,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       accept,
    output logic       retire,
    output logic       bus_err
);

    state_e      state_q, state_d;
    logic [15:0] wcnt_q, wcnt_d;
    logic        err_q, err_d;
    logic        legal, is_ld, is_st;
    opcode_e     opc;

    assign opc = opcode_e'(op);

    always_comb begin
        legal = 1'b1;
        is_ld = 1'b0;
        is_st = 1'b0;
        unique case (opc)
            OP_LD: is_ld = 1'b1;
            OP_ST: is_st = 1'b1;
            OP_MV, OP_ADD, OP_SUB, OP_CMP, OP_JR, OP_JZR, OP_JNR,
            OP_CALLR, OP_MVI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MVHI,
            OP_J, OP_JZ, OP_JN, OP_CALL: ;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        retire  = 1'b0;
        err_d   = err_q;
        wcnt_d  = '0;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                mem_rd = 1'b1;
                if (!waitreq) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else if (ILLEGAL_HALT) begin
                    state_d = S_HALT;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_rd = is_ld;
                mem_wr = is_st;
                if (!waitreq) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_BOOT;
        endcase
        // counter holds the stall cycles already spent on this access
        if ((mem_rd || mem_wr) && waitreq) begin
            if (WAIT_MAX > 0 && wcnt_q == 16'(WAIT_MAX)) begin
                err_d   = 1'b1;
                state_d = S_HALT;
            end else begin
                wcnt_d = wcnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign state   = state_q;
    assign accept  = (mem_rd || mem_wr) && !waitreq;
    assign bus_err = err_q;

endmodule

// File: rtl/cpu_mc.sv
// Multicycle 16-bit core with a shared wait-state bus port.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter bit          ILLEGAL_HALT = 1'b1,
    parameter int          WAIT_MAX     = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_wrdata,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_waitrequest,
    output logic        o_retire,
    output logic        o_halted,
    output logic        o_bus_err
);

    state_e      st;
    logic        mem_rd, mem_wr, acc, retire, bus_err;
    logic [15:0] pc_q, pc_d, pcn_q, pcn_d, ir_q, ir_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        n_q, n_d, z_q, z_d;
    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];
    logic [2:0]  rx, ry;
    logic [15:0] imm8, imm11, jtgt, alu;
    logic        fl;
    opcode_e     opc;

    cpu_mc_ctrl #(
        .ILLEGAL_HALT(ILLEGAL_HALT),
        .WAIT_MAX    (WAIT_MAX)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .op     (ir_q[OP_LSB +: 5]),
        .waitreq(i_mem_waitrequest),
        .state  (st),
        .mem_rd (mem_rd),
        .mem_wr (mem_wr),
        .accept (acc),
        .retire (retire),
        .bus_err(bus_err)
    );

    assign opc   = opcode_e'(ir_q[OP_LSB +: 5]);
    assign rx    = ir_q[RX_LSB +: 3];
    assign ry    = ir_q[RY_LSB +: 3];
    assign imm8  = sext({3'b000, ir_q[IMM8_LSB +: 8]}, 1'b0);
    assign imm11 = sext(ir_q[IMM11_LSB +: 11], 1'b1);
    assign jtgt  = pcn_q + {imm11[14:0], 1'b0};

    always_comb begin
        pc_d  = pc_q;
        pcn_d = pcn_q;
        ir_d  = ir_q;
        a_d   = a_q;
        b_d   = b_q;
        n_d   = n_q;
        z_d   = z_q;
        rf_d  = rf_q;
        alu   = '0;
        fl    = 1'b0;
        case (st)
            S_FETCH: begin
                if (acc) begin
                    ir_d  = i_mem_rddata;
                    pcn_d = pc_q + 16'd2;
                end
            end
            S_DECODE: begin
                a_d = rf_q[rx];
                b_d = rf_q[ry];
                if (retire) pc_d = pcn_q;
            end
            S_EXEC: begin
                if (retire) begin
                    pc_d = pcn_q;
                    case (opc)
                        OP_MV:   rf_d[rx] = b_q;
                        OP_MVI:  rf_d[rx] = imm8;
                        OP_MVHI: rf_d[rx] = {ir_q[IMM8_LSB +: 8], a_q[7:0]};
                        OP_ADD:  begin alu = a_q + b_q;  rf_d[rx] = alu; fl = 1'b1; end
                        OP_SUB:  begin alu = a_q - b_q;  rf_d[rx] = alu; fl = 1'b1; end
                        OP_ADDI: begin alu = a_q + imm8; rf_d[rx] = alu; fl = 1'b1; end
                        OP_SUBI: begin alu = a_q - imm8; rf_d[rx] = alu; fl = 1'b1; end
                        OP_CMP:  begin alu = a_q - b_q;  fl = 1'b1; end
                        OP_CMPI: begin alu = a_q - imm8; fl = 1'b1; end
                        OP_JR:   pc_d = a_q;
                        OP_JZR:  if (z_q) pc_d = a_q;
                        OP_JNR:  if (n_q) pc_d = a_q;
                        OP_CALLR: begin rf_d[7] = pcn_q; pc_d = a_q; end
                        OP_J:    pc_d = jtgt;
                        OP_JZ:   if (z_q) pc_d = jtgt;
                        OP_JN:   if (n_q) pc_d = jtgt;
                        OP_CALL: begin rf_d[7] = pcn_q; pc_d = jtgt; end
                        default: ;
                    endcase
                    if (fl) begin
                        z_d = (alu == 16'h0000);
                        n_d = alu[15];
                    end
                end
            end
            S_MEM: begin
                if (acc) begin
                    pc_d = pcn_q;
                    if (opc == OP_LD) rf_d[rx] = i_mem_rddata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            pcn_q <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            n_q   <= 1'b0;
            z_q   <= 1'b0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            pcn_q <= pcn_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            n_q   <= n_d;
            z_q   <= z_d;
            rf_q  <= rf_d;
        end
    end

    // bus outputs are gated so idle, reset and halt all present zeros
    assign o_mem_rd     = mem_rd;
    assign o_mem_wr     = mem_wr;
    assign o_mem_addr   = (mem_rd || mem_wr) ? ((st == S_FETCH) ? pc_q : b_q) : '0;
    assign o_mem_wrdata = mem_wr ? a_q : '0;
    assign o_retire     = retire;
    assign o_halted     = (st == S_HALT);
    assign o_bus_err    = bus_err;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: program flow, wait states, illegal ops, timeout.
module tb_cpu_mc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_c = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic [15:0] a_addr, a_wd, a_rdata;
    logic        a_rd, a_wr, a_wait, a_ret, a_halt, a_err;
    logic [15:0] b_addr, b_wd, b_rdata;
    logic        b_rd, b_wr, b_ret, b_halt, b_err;
    logic [15:0] c_addr, c_wd;
    logic        c_rd, c_wr, c_ret, c_halt, c_err;

    logic [15:0] ram [0:255];
    logic [15:0] last_wa = '0;
    logic [15:0] last_wd = '0;
    int          wst = 0;

    cpu_mc #(.RESET_PC(16'h0000), .ILLEGAL_HALT(1'b1), .WAIT_MAX(0)) dut_a (
        .clk(clk), .reset(rst),
        .o_mem_addr(a_addr), .o_mem_rd(a_rd), .o_mem_wr(a_wr),
        .o_mem_wrdata(a_wd), .i_mem_rddata(a_rdata),
        .i_mem_waitrequest(a_wait),
        .o_retire(a_ret), .o_halted(a_halt), .o_bus_err(a_err)
    );

    cpu_mc #(.RESET_PC(16'h0000), .ILLEGAL_HALT(1'b0), .WAIT_MAX(0)) dut_b (
        .clk(clk), .reset(rst),
        .o_mem_addr(b_addr), .o_mem_rd(b_rd), .o_mem_wr(b_wr),
        .o_mem_wrdata(b_wd), .i_mem_rddata(b_rdata),
        .i_mem_waitrequest(1'b0),
        .o_retire(b_ret), .o_halted(b_halt), .o_bus_err(b_err)
    );

    cpu_mc #(.RESET_PC(16'h0080), .ILLEGAL_HALT(1'b1), .WAIT_MAX(4)) dut_c (
        .clk(clk), .reset(rst_c),
        .o_mem_addr(c_addr), .o_mem_rd(c_rd), .o_mem_wr(c_wr),
        .o_mem_wrdata(c_wd), .i_mem_rddata(16'h0000),
        .i_mem_waitrequest(1'b1),
        .o_retire(c_ret), .o_halted(c_halt), .o_bus_err(c_err)
    );

    function automatic logic [15:0] rom_a(input logic [15:0] ad);
        case (ad)
            16'h0000: return 16'h0410; // mvi R0,4
            16'h0002: return 16'h0311; // addi R0,3
            16'h0004: return 16'h00B8; // j +5 -> 0x10
            16'h000C: return 16'h00E8; // jr R7
            16'h0010: return 16'hFFBC; // call -3
            16'h0012: return 16'h0713; // cmpi R0,7
            16'h0014: return 16'h0059; // jz +2
            16'h001A: return 16'h0610; // mvi R0,6
            16'h001C: return 16'h0713; // cmpi R0,7
            16'h001E: return 16'h0059; // jz +2
            16'h0020: return 16'hEF30; // mvi R1,0xEF
            16'h0022: return 16'hBE36; // mvhi R1,0xBE
            16'h0024: return 16'h0050; // mvi R2,0
            16'h0026: return 16'h0156; // mvhi R2,1
            16'h0028: return 16'h0225; // st R1,[R2]
            16'h002A: return 16'h0264; // ld R3,[R2]
            16'h002C: return 16'h0244; // ld R2,[R2]
            16'h002E: return 16'h40B0; // mvi R5,0x40
            16'h0030: return 16'h05A5; // st R5,[R5]
            16'h0032: return 16'h0262; // sub R3,R2
            16'h0034: return 16'h01C0; // mv R6,R1
            default:  return 16'h001F; // illegal
        endcase
    endfunction

    function automatic logic [15:0] rom_b(input logic [15:0] ad);
        case (ad)
            16'h0002: return 16'h0410;
            16'h0004: return 16'hFFF8;
            default:  return 16'h001F;
        endcase
    endfunction

    assign a_wait = a_wr && (wst < 3);

    always_comb begin
        a_rdata = (a_addr < 16'h0040) ? rom_a(a_addr) : ram[a_addr[8:1]];
        b_rdata = rom_b(b_addr);
    end

    always @(posedge clk) begin
        wst <= (a_wr && a_wait) ? wst + 1 : 0;
        if (a_wr && !a_wait) begin
            ram[a_addr[8:1]] <= a_wd;
            last_wa <= a_addr;
            last_wd <= a_wd;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] exp);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = a_ret;
        end
        if (!seen) chk({tag, "_timeout"}, 16'h0000, 16'h0001);
        @(negedge clk);
        chk(tag, a_rd ? a_addr : 16'hFFFF, exp);
    endtask

    logic [6:0] rdt, rtt;
    int         wrc, bad, reqs;
    logic       ret_wr;

    initial begin
        rdt = '0;
        rtt = '0;
        repeat (2) @(negedge clk);
        chk("rst_a_ctl", 16'({a_rd, a_wr, a_ret, a_halt, a_err}), 16'h0000);
        chk("rst_a_bus", a_addr | a_wd, 16'h0000);
        chk("rst_b_ctl", 16'({b_rd, b_wr, b_ret, b_halt, b_err}), 16'h0000);
        chk("rst_b_wd", b_wd, 16'h0000);

        rst = 1'b1;
        rdt[0] = a_rd;
        rtt[0] = a_ret;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            rdt[k] = a_rd;
            rtt[k] = a_ret;
            if (k == 1) chk("first_addr", a_addr, 16'h0000);
            if (k == 2) chk("ill_retire", 16'({b_ret, b_halt}), 16'h0002);
            if (k == 3) chk("ill_next", b_rd ? b_addr : 16'hFFFF, 16'h0002);
        end
        chk("rd_trace", 16'(rdt), 16'h0012);
        chk("ret_trace", 16'(rtt), 16'h0048);
        @(negedge clk);
        chk("r0_7", dut_a.rf_q[0], 16'h0007);
        chk("nz_0", 16'({dut_a.n_q, dut_a.z_q}), 16'h0000);
        chk("fetch_4", a_rd ? a_addr : 16'hFFFF, 16'h0004);

        step("j", 16'h0010);
        step("call", 16'h000C);
        chk("r7_link", dut_a.rf_q[7], 16'h0012);
        step("jr_r7", 16'h0012);
        step("cmpi_eq", 16'h0014);
        chk("z_set", 16'({dut_a.n_q, dut_a.z_q}), 16'h0001);
        step("jz_taken", 16'h001A);
        step("mvi_6", 16'h001C);
        step("cmpi_lt", 16'h001E);
        chk("n_set", 16'({dut_a.n_q, dut_a.z_q}), 16'h0002);
        step("jz_not", 16'h0020);
        step("mvi_r1", 16'h0022);
        step("mvhi_r1", 16'h0024);
        chk("r1_beef", dut_a.rf_q[1], 16'hBEEF);
        step("mvi_r2", 16'h0026);
        step("mvhi_r2", 16'h0028);
        chk("r2_100", dut_a.rf_q[2], 16'h0100);

        wrc = 0;
        bad = 0;
        ret_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_wr) begin
                wrc++;
                if (a_addr != 16'h0100 || a_wd != 16'hBEEF) bad++;
            end
            if (a_ret) begin
                ret_wr = a_wr;
                break;
            end
        end
        chk("st_cycles", 16'(wrc), 16'h0004);
        chk("st_stable", 16'(bad), 16'h0000);
        chk("st_retire", 16'(ret_wr), 16'h0001);
        @(negedge clk);
        chk("st_next", a_rd ? a_addr : 16'hFFFF, 16'h002A);
        chk("st_once", 16'(a_ret), 16'h0000);

        step("ld_r3", 16'h002C);
        chk("r3_beef", dut_a.rf_q[3], 16'hBEEF);
        step("ld_same", 16'h002E);
        chk("r2_beef", dut_a.rf_q[2], 16'hBEEF);
        step("mvi_r5", 16'h0030);
        step("st_same", 16'h0032);
        chk("st_same_a", last_wa, 16'h0040);
        chk("st_same_d", last_wd, 16'h0040);
        step("sub", 16'h0034);
        chk("r3_zero", dut_a.rf_q[3], 16'h0000);
        chk("sub_flags", 16'({dut_a.n_q, dut_a.z_q}), 16'h0001);
        step("mv", 16'h0036);
        chk("r6_beef", dut_a.rf_q[6], 16'hBEEF);

        reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (a_rd || a_wr) reqs++;
        end
        chk("halt_flag", 16'(a_halt), 16'h0001);
        chk("halt_quiet", 16'(reqs), 16'h0000);

        rst_c = 1'b1;
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            if (k == 1) chk("c_addr", c_addr, 16'h0080);
            if (k == 5) begin
                chk("c_stall5", 16'({c_rd, c_wr, c_halt, c_err}), 16'h0008);
                chk("c_wd", c_wd, 16'h0000);
            end
            if (k == 6) begin
                chk("c_tmo", 16'({c_rd, c_halt, c_err, c_ret}), 16'h0006);
            end
        end
        rst_c = 1'b0;
        #1;
        chk("c_err_clr", 16'({c_halt, c_err}), 16'h0000);
        @(negedge clk);
        rst_c = 1'b1;
        repeat (3) @(negedge clk);
        chk("c_mid_rd", 16'(c_rd), 16'h0001);
        rst_c = 1'b0;
        #1;
        chk("c_drop", 16'(c_rd), 16'h0000);
        @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        chk("c_restart", c_rd ? c_addr : 16'hFFFF, 16'h0080);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_mc.md
Name: cpu_mc

Overview:
- Multicycle successor to the single-cycle 16-bit core.
- Same 16-bit ISA and encoding. Adds a wait-state memory handshake (waitrequest), an instruction register, a separate data-access phase, and illegal-opcode handling.
- A retire strobe and halt status support verification and system integration.
- Sits between the system bus (single shared instruction/data port) and nothing else; one instance per SoC.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ILLEGAL_HALT, 1, 1: an undefined opcode enters HALT; 0: it retires as a no-op.
- WAIT_MAX, 0, maximum waitrequest cycles per access before o_bus_err; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- o_mem_addr  out  16  byte address
- o_mem_rd  out  1  read request, held until accepted
- o_mem_wr  out  1  write request, held until accepted
- o_mem_wrdata  out  16  store data
- i_mem_rddata  in  16  read data, valid in the cycle the request is accepted
- i_mem_waitrequest  in  1  1 = stall; a request is accepted in a cycle with rd|wr=1 and waitrequest=0
- o_retire  out  1  one-cycle pulse per completed instruction
- o_halted  out  1  core is in HALT
- o_bus_err  out  1  sticky; a timeout occurred

Behaviour:
- Encoding:
  - opcode [4:0], Rx [7:5], Ry [10:8], imm8 [15:8], imm11 [15:5]; immediates are sign-extended.
  - Register-register opcodes: mv 00, add 01, sub 02, cmp 03, ld 04, st 05, jr 08, jzr 09, jnr 0A, callr 0C.
  - Immediate opcodes: mvi 10, addi 11, subi 12, cmpi 13, mvhi 16, j 18, jz 19, jn 1A, call 1C.
  - All other opcodes are illegal.
- States: BOOT, FETCH, DECODE, EXEC, MEM, HALT.
- Reset asserted:
  - State = BOOT, PC = RESET_PC, IR = 0, N = Z = 0.
  - All outputs 0; R0..R7 = 0.
  - Reset mid-access drops rd/wr immediately.
- BOOT: next cycle goes to FETCH.
- FETCH:
  - o_mem_rd = 1, o_mem_addr = PC.
  - On accept: IR <= rddata, PCN <= PC+2, go to DECODE.
- DECODE:
  - Latch A <= R[Rx], B <= R[Ry], imm.
  - Illegal opcode: HALT if ILLEGAL_HALT, else retire with PC <= PCN and go to FETCH.
- EXEC, single-cycle completion:
  - mv, mvi, add(i), sub(i): write Rx.
  - cmp(i): sets flags only.
  - mvhi: Rx <= {imm8, A[7:0]}.
  - Register jumps use target = A. Immediate jumps use target = PCN + 2*sext(imm11); jz and jn use imm11 the same way.
  - Conditional jumps take the branch if Z (jz/jzr) or N (jn/jnr) is set, else PC <= PCN.
  - call/callr: R7 <= PCN and PC <= target, in the same cycle.
  - Non-jump instructions: PC <= PCN.
  - Completion pulses o_retire and goes to FETCH.
  - ld/st instead go to MEM.
- MEM:
  - Address = B (Ry).
  - ld: o_mem_rd = 1. On accept Rx <= rddata, PC <= PCN, retire.
  - st: o_mem_wr = 1, wrdata = A. On accept PC <= PCN, retire.
- Flags:
  - Only add, sub, cmp, addi, subi, cmpi update them.
  - Z = (result == 0), N = result[15]; arithmetic is modulo 2^16.
  - The Rx written by call/callr is R7 regardless of the Rx field.
- Latency at zero wait:
  - ALU/jump instructions: 3 cycles.
  - ld/st: 4 cycles.
  - Each wait cycle adds 1.
- Handshake: addr, rd, wr and wrdata are stable while waitrequest = 1.
- Timeout: if WAIT_MAX > 0 and a single access stalls more than WAIT_MAX cycles:
  - Set o_bus_err, drop the request, enter HALT.
- HALT:
  - Absorbing; all requests deasserted; o_halted = 1.
  - Exit only via reset.
- Same-register cases:
  - ld with Rx == Ry writes loaded data.
  - st with Rx == Ry stores the address value.

Decomposition:
- Package cpu_mc_pkg:
  - opcode enum with the values above
  - state enum
  - field-position localparams
  - sext helper function
- One sub-module is natural: cpu_mc_ctrl (FSM, decode, wait/timeout counter).
- Datapath, register file and ALU stay in the top.

Test Plan:
- Reset release, zero wait, memory {0x0410 mvi R0,4 ; 0x0311 addi R0,3}:
  - First rd at addr 0 in cycle 2 after release; R0 = 7; o_retire pulses at cycles 4 and 7; N = Z = 0.
- cmpi R0,7 then jz +2 (imm11 = 2):
  - Z = 1; next fetch address = PC+2+4.
  - With R0 = 6 instead: fetch at PC+2.
- call -3 at 0x0010:
  - R7 = 0x0012, next fetch 0x000C.
  - jr R7 returns fetch to 0x0012.
- st R1→[R2] with R1 = 0xBEEF, R2 = 0x0100, waitrequest high for 3 cycles:
  - wr, addr 0x0100 and wrdata 0xBEEF held stable 4 cycles; single retire.
  - Then ld R3←[R2] returns 0xBEEF into R3.
- Illegal opcode 0x1F:
  - ILLEGAL_HALT = 1: o_halted = 1, no further requests.
  - ILLEGAL_HALT = 0: retired, next fetch PC+2.
- WAIT_MAX = 4, waitrequest stuck high: o_bus_err and o_halted both set after the 5th stall cycle. Reset asserted mid-stall drops o_mem_rd the same cycle and restarts from RESET_PC.
